// File: rtl/dmem_store_unit.sv
// dmem_store_unit: write-side store buffer for the 16-word data memory.
// Core stores are accepted over a valid/ready handshake into a DEPTH-entry
// FIFO and drained in order through an output register that drives the
// memory WE/A/WD/BE inputs, one write per granted cycle.
// Optional feature macro: STORE_FWD_EN builds store-to-load forwarding;
// without it the fwd_* outputs are tied to zero and no comparators exist.
module dmem_store_unit #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         st_valid,
    output logic                         st_ready,
    input  logic [AW-1:0]                st_addr,
    input  logic [DW-1:0]                st_data,
    input  logic [DW/8-1:0]              st_be,
    input  logic                         mem_gnt,
    output logic                         WE,
    output logic [AW-1:0]                A,
    output logic [DW-1:0]                WD,
    output logic [DW/8-1:0]              BE,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    input  logic [AW-1:0]                fwd_addr,
    output logic                         fwd_hit,
    output logic [DW-1:0]                fwd_data,
    output logic [DW/8-1:0]              fwd_be
);

    localparam int BW  = DW / 8;
    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int WAW = AW - 2;

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_t;

    // FIFO storage keeps only the word address; byte offset is dropped on entry
    logic [WAW-1:0] fifo_addr_r [DEPTH];
    logic [DW-1:0]  fifo_data_r [DEPTH];
    logic [BW-1:0]  fifo_be_r   [DEPTH];

    logic [PW-1:0]  wr_ptr_r;
    logic [PW-1:0]  rd_ptr_r;
    logic [CW-1:0]  count_r;

    state_t         state_r;
    logic           we_r;
    logic [WAW-1:0] a_r;
    logic [DW-1:0]  wd_r;
    logic [BW-1:0]  be_r;

    logic           push_s;
    logic           pop_s;
    logic           unused_s;

    // ready depends on registered occupancy only, so a same-cycle pop never raises it
    assign st_ready = (count_r < DEPTH_C);
    // zero-enable stores complete the handshake but never occupy a slot
    assign push_s   = st_valid && st_ready && (st_be != {BW{1'b0}});
    // head moves into the output register when it is idle or its write completes now
    assign pop_s    = (count_r != CNT_ZERO) && (!we_r || mem_gnt);

    assign WE    = we_r;
    assign A     = {a_r, 2'b00};
    assign WD    = wd_r;
    assign BE    = be_r;
    assign count = count_r;
    assign empty = (count_r == CNT_ZERO) && !we_r;

    // FIFO storage: write accepted stores at the tail
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_addr_r[i] <= {WAW{1'b0}};
                fifo_data_r[i] <= {DW{1'b0}};
                fifo_be_r[i]   <= {BW{1'b0}};
            end
        end else if (push_s) begin
            fifo_addr_r[wr_ptr_r] <= st_addr[AW-1:2];
            fifo_data_r[wr_ptr_r] <= st_data;
            fifo_be_r[wr_ptr_r]   <= st_be;
        end
    end

    // FIFO pointers and occupancy; push+pop together leaves count unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Write FSM and output register: load head, hold while ungranted, chain back-to-back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            we_r    <= 1'b0;
            a_r     <= {WAW{1'b0}};
            wd_r    <= {DW{1'b0}};
            be_r    <= {BW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        state_r <= ST_WRITE;
                        we_r    <= 1'b1;
                        a_r     <= fifo_addr_r[rd_ptr_r];
                        wd_r    <= fifo_data_r[rd_ptr_r];
                        be_r    <= fifo_be_r[rd_ptr_r];
                    end
                end
                ST_WRITE: begin
                    if (mem_gnt) begin
                        if (pop_s) begin
                            a_r  <= fifo_addr_r[rd_ptr_r];
                            wd_r <= fifo_data_r[rd_ptr_r];
                            be_r <= fifo_be_r[rd_ptr_r];
                        end else begin
                            state_r <= ST_IDLE;
                            we_r    <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    we_r    <= 1'b0;
                end
            endcase
        end
    end

`ifdef STORE_FWD_EN
    logic           fwd_hit_s;
    logic [DW-1:0]  fwd_data_s;
    logic [BW-1:0]  fwd_be_s;

    assign unused_s = ^{st_addr[1:0], fwd_addr[1:0]};

    // Forwarding lookup: scan oldest (output register) to youngest so the last match wins
    always_comb begin
        fwd_hit_s  = 1'b0;
        fwd_data_s = {DW{1'b0}};
        fwd_be_s   = {BW{1'b0}};
        if (we_r && (a_r == fwd_addr[AW-1:2])) begin
            fwd_hit_s  = 1'b1;
            fwd_data_s = wd_r;
            fwd_be_s   = be_r;
        end else begin
            fwd_hit_s  = 1'b0;
        end
        for (int k = 0; k < DEPTH; k++) begin
            if ((CW'(k) < count_r) &&
                (fifo_addr_r[rd_ptr_r + PW'(k)] == fwd_addr[AW-1:2])) begin
                fwd_hit_s  = 1'b1;
                fwd_data_s = fifo_data_r[rd_ptr_r + PW'(k)];
                fwd_be_s   = fifo_be_r[rd_ptr_r + PW'(k)];
            end else begin
                fwd_hit_s  = fwd_hit_s;
            end
        end
    end

    assign fwd_hit  = fwd_hit_s;
    assign fwd_data = fwd_data_s;
    assign fwd_be   = fwd_be_s;
`else
    assign unused_s = ^{st_addr[1:0], fwd_addr};

    assign fwd_hit  = 1'b0;
    assign fwd_data = {DW{1'b0}};
    assign fwd_be   = {BW{1'b0}};
`endif

endmodule
